// File: rtl/flappy_pkg.sv
// flappy_pkg: shared definitions for the Flappy game-level datapath.
//   game_t   : one-hot Initial/Play/Lose encoding (bit 0 = Initial, 1 = Play, 2 = Lose)
//   seq_t    : per-frame update sequencer states
//   V_ACTIVE_DEF / V_TOTAL : vertical timing of the 640x480 sync generator
//   SCORE_W  : width of the score and miss counters
//   sat_inc  : saturating increment for SCORE_W-wide counters
package flappy_pkg;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL      = 525;
    localparam int SCORE_W      = 8;

    typedef enum logic [2:0] {
        G_INITIAL = 3'b001,
        G_PLAY    = 3'b010,
        G_LOSE    = 3'b100
    } game_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_PHYS,
        S_SCROLL,
        S_COLL,
        S_COMMIT
    } seq_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_update_scheduler_step_watchdog.sv
// step_watchdog: loadable cycle counter shared by all update steps.
//   clk, reset : system clock, synchronous active-high reset
//   load       : restart the count from zero (asserted the cycle before a step begins)
//   run        : a step is in progress; count advances while high
//   expired    : count has reached TIMEOUT
module step_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired
);
    // +2 keeps the counter at least one bit wide even for TIMEOUT = 0
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (run && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: once per (divided) vertical blank, runs flight physics,
// pipe scroll and collision check in order over go/done handshakes, then commits.
// Owns the Initial/Play/Lose game state, score, jump latch and handshake watchdog.
//   clk, reset               : system clock, synchronous active-high reset
//   counter_y                : current row from the sync generator
//   start, ack, jump         : single-cycle debounced button pulses
//   phys_go/phys_jump/phys_done            : flight physics handshake
//   scroll_go/scroll_done/scroll_pass      : pipe scroll handshake
//   coll_go/coll_done/coll_hit             : collision check handshake
//   commit                   : publish new positions to the renderer
//   q_initial/q_play/q_lose  : one-hot game state
//   score, fault, miss_cnt   : score, sticky timeout flag, skipped-frame count
module frame_update_scheduler
    import flappy_pkg::*;
#(
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int FRAME_DIV = 1,
    parameter int TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] counter_y,
    input  logic       start,
    input  logic       ack,
    input  logic       jump,
    output logic       phys_go,
    output logic       phys_jump,
    input  logic       phys_done,
    output logic       scroll_go,
    input  logic       scroll_done,
    input  logic       scroll_pass,
    output logic       coll_go,
    input  logic       coll_done,
    input  logic       coll_hit,
    output logic       commit,
    output logic       q_initial,
    output logic       q_play,
    output logic       q_lose,
    output logic [7:0] score,
    output logic       fault,
    output logic [7:0] miss_cnt
);
    localparam logic [9:0] V_ROW    = 10'(V_ACTIVE);
    localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

    game_t      game, game_n;
    seq_t       seq, seq_n;
    logic [9:0] prev_y;
    logic [3:0] div;
    logic       jlatch, jlatch_n, pending;
    logic       phys_go_n, scroll_go_n, coll_go_n, commit_n, phys_jump_n;
    logic       in_play, new_game, vb_edge, fire;
    logic       phys_acc, scroll_acc, coll_acc, step_busy, expired, timed_out;

    assign in_play  = (game == G_PLAY);
    assign new_game = (game == G_INITIAL) && start;
    assign vb_edge  = (counter_y == V_ROW) && (prev_y != V_ROW);
    assign fire     = in_play && vb_edge && (div == DIV_LAST);

    // The go strobe is high exactly in a step's first cycle, so it doubles as
    // the "ignore done this cycle" qualifier.
    assign phys_acc   = (seq == S_PHYS)   && !phys_go   && phys_done;
    assign scroll_acc = (seq == S_SCROLL) && !scroll_go && scroll_done;
    assign coll_acc   = (seq == S_COLL)   && !coll_go   && coll_done;
    assign step_busy  = (seq == S_PHYS) || (seq == S_SCROLL) || (seq == S_COLL);
    // A done arriving on the expiry cycle still wins over the timeout.
    assign timed_out  = step_busy && expired && !(phys_acc || scroll_acc || coll_acc);

    step_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (phys_go_n || scroll_go_n || coll_go_n),
        .run     (step_busy),
        .expired (expired)
    );

    always_comb begin
        game_n      = game;
        seq_n       = seq;
        phys_go_n   = 1'b0;
        scroll_go_n = 1'b0;
        coll_go_n   = 1'b0;
        commit_n    = 1'b0;
        jlatch_n    = jlatch;

        case (game)
            G_INITIAL: if (start) game_n = G_PLAY;
            G_PLAY:    if ((coll_acc && coll_hit) || timed_out) game_n = G_LOSE;
            G_LOSE:    if (ack) game_n = G_INITIAL;
            default:   game_n = G_INITIAL;
        endcase

        case (seq)
            S_WAIT: if (fire) begin
                seq_n     = S_PHYS;
                phys_go_n = 1'b1;
            end
            S_PHYS: if (phys_acc) begin
                seq_n       = S_SCROLL;
                scroll_go_n = 1'b1;
            end
            S_SCROLL: if (scroll_acc) begin
                seq_n     = S_COLL;
                coll_go_n = 1'b1;
            end
            S_COLL: if (coll_acc) begin
                if (coll_hit) begin
                    seq_n = S_WAIT;
                end else begin
                    seq_n    = S_COMMIT;
                    commit_n = 1'b1;
                end
            end
            S_COMMIT: seq_n = S_WAIT;
            default:  seq_n = S_WAIT;
        endcase

        // Leaving (or not in) Play cancels everything in flight.
        if (game_n != G_PLAY) begin
            seq_n       = S_WAIT;
            phys_go_n   = 1'b0;
            scroll_go_n = 1'b0;
            coll_go_n   = 1'b0;
            commit_n    = 1'b0;
        end

        // A jump in the same cycle as the accepted done is kept for next frame.
        if (!in_play) begin
            jlatch_n = 1'b0;
        end else begin
            if (phys_acc) jlatch_n = 1'b0;
            if (jump)     jlatch_n = 1'b1;
        end

        phys_jump_n = (seq_n == S_PHYS) && jlatch_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            game      <= G_INITIAL;
            seq       <= S_WAIT;
            prev_y    <= '0;
            div       <= '0;
            jlatch    <= 1'b0;
            pending   <= 1'b0;
            score     <= '0;
            fault     <= 1'b0;
            miss_cnt  <= '0;
            phys_go   <= 1'b0;
            scroll_go <= 1'b0;
            coll_go   <= 1'b0;
            commit    <= 1'b0;
            phys_jump <= 1'b0;
        end else begin
            game      <= game_n;
            seq       <= seq_n;
            prev_y    <= counter_y;
            jlatch    <= jlatch_n;
            phys_go   <= phys_go_n;
            scroll_go <= scroll_go_n;
            coll_go   <= coll_go_n;
            commit    <= commit_n;
            phys_jump <= phys_jump_n;

            if (new_game) begin
                div <= '0;
            end else if (in_play && vb_edge) begin
                div <= (div == DIV_LAST) ? 4'd0 : div + 1'b1;
            end

            if (new_game) begin
                score   <= '0;
                pending <= 1'b0;
            end else if (commit) begin
                if (pending) score <= sat_inc(score);
                pending <= 1'b0;
            end else if (game_n != G_PLAY) begin
                pending <= 1'b0;
            end else if (scroll_acc && scroll_pass) begin
                pending <= 1'b1;
            end

            if (timed_out) fault <= 1'b1;

            // Overrun: the frame is dropped, never queued.
            if (fire && seq != S_WAIT) miss_cnt <= sat_inc(miss_cnt);
        end
    end

    assign q_initial = game[0];
    assign q_play    = game[1];
    assign q_lose    = game[2];

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: table-driven frames plus hand-written
// sequences, with a strobe scoreboard and a second instance at FRAME_DIV=2.
module tb_frame_update_scheduler;

    localparam int EV_PGO = 0;
    localparam int EV_SGO = 1;
    localparam int EV_CGO = 2;
    localparam int EV_CMT = 3;

    typedef struct { int kind; int cyc; } ev_t;
    typedef struct { bit pass; bit hit; int exp_score; bit exp_lose; } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] counter_y = '0;
    logic       start = 1'b0, ack = 1'b0, jump = 1'b0;
    logic       phys_done = 1'b0, scroll_done = 1'b0, scroll_pass = 1'b0;
    logic       coll_done = 1'b0, coll_hit = 1'b0;
    logic       phys_go, phys_jump, scroll_go, coll_go, commit;
    logic       q_initial, q_play, q_lose, fault;
    logic [7:0] score, miss_cnt;
    logic       phys_go2, phys_jump2, scroll_go2, coll_go2, commit2;
    logic       q_initial2, q_play2, q_lose2, fault2;
    logic [7:0] score2, miss_cnt2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   phys_hold = 1'b0;
    bit   pass_v = 1'b0;
    bit   hit_v = 1'b0;
    int   coll_delay = 3;
    int   n_pgo2 = 0, n_sgo2 = 0, n_cgo2 = 0, n_cmt2 = 0;
    ev_t  sbq[$];
    vec_t tbl[4];

    frame_update_scheduler #(.V_ACTIVE(480), .FRAME_DIV(1), .TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .counter_y(counter_y), .start(start), .ack(ack), .jump(jump),
        .phys_go(phys_go), .phys_jump(phys_jump), .phys_done(phys_done),
        .scroll_go(scroll_go), .scroll_done(scroll_done), .scroll_pass(scroll_pass),
        .coll_go(coll_go), .coll_done(coll_done), .coll_hit(coll_hit), .commit(commit),
        .q_initial(q_initial), .q_play(q_play), .q_lose(q_lose),
        .score(score), .fault(fault), .miss_cnt(miss_cnt)
    );

    frame_update_scheduler #(.V_ACTIVE(480), .FRAME_DIV(2), .TIMEOUT(1023)) dut2 (
        .clk(clk), .reset(reset), .counter_y(counter_y), .start(start), .ack(ack), .jump(jump),
        .phys_go(phys_go2), .phys_jump(phys_jump2), .phys_done(phys_done),
        .scroll_go(scroll_go2), .scroll_done(scroll_done), .scroll_pass(scroll_pass),
        .coll_go(coll_go2), .coll_done(coll_done), .coll_hit(coll_hit), .commit(commit2),
        .q_initial(q_initial2), .q_play(q_play2), .q_lose(q_lose2),
        .score(score2), .fault(fault2), .miss_cnt(miss_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic sb_push(input int kind, input int c);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = c;
        sbq.push_back(ev);
    endtask

    task automatic sb_pop(input int kind);
        ev_t ev;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: strobe kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            ev = sbq.pop_front();
            chk("sb_kind", kind, ev.kind);
            chk("sb_cycle", cyc, ev.cyc);
        end
    endtask

    // mode 0: edge expected to be dropped; 1: full frame; 2: physics go only.
    // Returns e = cycle in which counter_y first reads 480.
    task automatic vblank(input int mode, input bit hit, input int cdly, output int e);
        counter_y = 10'd479;
        step();
        counter_y = 10'd480;
        e = cyc;
        if (mode != 0) sb_push(EV_PGO, e + 1);
        if (mode == 1) begin
            sb_push(EV_SGO, e + 5);
            sb_push(EV_CGO, e + 9);
            if (!hit) sb_push(EV_CMT, e + 10 + cdly);
        end
        step();
        counter_y = 10'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
    endtask

    initial begin : resp_phys
        forever begin
            step();
            if (phys_go && !phys_hold) begin
                repeat (3) @(posedge clk);
                #1 phys_done = 1'b1;
                @(posedge clk);
                #1 phys_done = 1'b0;
            end
        end
    end

    initial begin : resp_scroll
        forever begin
            step();
            if (scroll_go) begin
                repeat (3) @(posedge clk);
                #1;
                scroll_done = 1'b1;
                scroll_pass = pass_v;
                @(posedge clk);
                #1;
                scroll_done = 1'b0;
                scroll_pass = 1'b0;
            end
        end
    end

    initial begin : resp_coll
        forever begin
            step();
            if (coll_go) begin
                repeat (coll_delay) @(posedge clk);
                #1;
                coll_done = 1'b1;
                coll_hit  = hit_v;
                @(posedge clk);
                #1;
                coll_done = 1'b0;
                coll_hit  = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            step();
            if (mon_en) begin
                chk("onehot", $countones({q_initial, q_play, q_lose}), 1);
                chk("onehot2", $countones({q_initial2, q_play2, q_lose2}), 1);
                if (phys_go)   sb_pop(EV_PGO);
                if (scroll_go) sb_pop(EV_SGO);
                if (coll_go)   sb_pop(EV_CGO);
                if (commit)    sb_pop(EV_CMT);
                if (phys_go2)   n_pgo2++;
                if (scroll_go2) n_sgo2++;
                if (coll_go2)   n_cgo2++;
                if (commit2)    n_cmt2++;
            end
        end
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int e;
        int e1;
        int e2;
        int div_exp[4];

        tbl[0] = '{1'b1, 1'b0, 1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 2, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 2, 1'b1};
        div_exp = '{0, 1, 1, 2};

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_q_initial", q_initial, 1);
        chk("rst_q_play", q_play, 0);
        chk("rst_q_lose", q_lose, 0);
        chk("rst_score", score, 0);
        chk("rst_fault", fault, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_strobes", {phys_go, scroll_go, coll_go, commit, phys_jump}, 0);
        chk("rst_q_initial2", q_initial2, 1);
        mon_en = 1'b1;

        pulse_start();
        chk("start_q_play", q_play, 1);
        chk("start_q_play2", q_play2, 1);

        // Frame divider on dut2, baseline frame timing on dut
        pass_v = 1'b0;
        hit_v  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vblank(1, 1'b0, 3, e);
            wait_until(e + 16);
            if (i == 0) chk("first_frame_score", score, 0);
            chk("div2_phys_go_count", n_pgo2, div_exp[i]);
            chk("div2_commit_count", n_cmt2, div_exp[i]);
        end
        chk("div2_scroll_count", n_sgo2, 2);
        chk("div2_coll_count", n_cgo2, 2);
        chk("div2_quiet", {score2, miss_cnt2, fault2, phys_jump2}, 0);
        chk("sb_drain_div", sbq.size(), 0);

        // Table-driven frames: pass/hit combinations
        for (int i = 0; i < 4; i++) begin
            pass_v = tbl[i].pass;
            hit_v  = tbl[i].hit;
            vblank(1, tbl[i].hit, 3, e);
            wait_until(e + 13);
            chk("tbl_q_lose", q_lose, tbl[i].exp_lose);
            wait_until(e + 16);
            chk("tbl_score", score, tbl[i].exp_score);
        end
        hit_v = 1'b0;
        chk("sb_drain_tbl", sbq.size(), 0);

        // start is ignored in Lose; ack returns to Initial
        pulse_start();
        chk("lose_ignores_start", {q_initial, q_play, q_lose}, 3'b001);
        pulse_ack();
        chk("ack_q_initial", q_initial, 1);
        pulse_start();
        chk("restart_q_play", q_play, 1);
        chk("restart_score_clear", score, 0);

        // Score saturation
        pass_v = 1'b1;
        for (int i = 0; i < 256; i++) begin
            vblank(1, 1'b0, 3, e);
            wait_until(e + 16);
            chk("sat_score", score, (i + 1 > 255) ? 255 : i + 1);
        end
        pass_v = 1'b0;
        chk("sb_drain_sat", sbq.size(), 0);

        // Jump during collision check, carried into the next physics step
        vblank(1, 1'b0, 3, e);
        wait_until(e + 10);
        jump = 1'b1;
        step();
        jump = 1'b0;
        chk("jump_idle_phys_jump", phys_jump, 0);
        wait_until(e + 16);
        vblank(1, 1'b0, 3, e);
        for (int k = 1; k <= 3; k++) begin
            wait_until(e + k);
            chk("jump_held_phys_jump", phys_jump, 1);
        end
        wait_until(e + 4);
        chk("jump_held_phys_jump", phys_jump, 1);
        jump = 1'b1;
        step();
        jump = 1'b0;
        chk("jump_clear_after_done", phys_jump, 0);
        wait_until(e + 16);
        vblank(1, 1'b0, 3, e);
        chk("jump_same_cycle_kept", phys_jump, 1);
        wait_until(e + 5);
        chk("jump_same_cycle_clear", phys_jump, 0);
        wait_until(e + 16);
        vblank(1, 1'b0, 3, e);
        chk("jump_none", phys_jump, 0);
        wait_until(e + 16);
        chk("sb_drain_jump", sbq.size(), 0);

        // Overrun: a vblank edge while collision check is still busy
        coll_delay = 20;
        vblank(1, 1'b0, 20, e1);
        wait_until(e1 + 13);
        vblank(0, 1'b0, 3, e2);
        chk("miss_cnt_overrun", miss_cnt, 1);
        wait_until(e1 + 32);
        coll_delay = 3;
        chk("sb_drain_miss", sbq.size(), 0);
        chk("miss_still_play", q_play, 1);

        // Handshake timeout
        phys_hold = 1'b1;
        vblank(2, 1'b0, 3, e);
        wait_until(e + 1024);
        chk("timeout_fault_early", fault, 0);
        chk("timeout_lose_early", q_lose, 0);
        step();
        chk("timeout_fault", fault, 1);
        chk("timeout_lose", q_lose, 1);
        pulse_ack();
        chk("timeout_ack_initial", q_initial, 1);
        chk("timeout_fault_sticky", fault, 1);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        phys_hold = 1'b0;
        chk("reset_fault_clear", fault, 0);
        chk("reset_q_initial", q_initial, 1);
        chk("reset_miss_clear", miss_cnt, 0);
        chk("reset_score_clear", score, 0);
        chk("sb_drain_end", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Game-level sequencer for the Flappy datapath. Once per video frame, during vertical blank, it runs the update units in a fixed order: flight physics, then pipe scroll, then collision check.
- Uses a go/done handshake with each unit. Owns the Initial/Play/Lose game state, the score, and the jump request latch.
- Sits between the VGA sync generator (row counter) and the physics, X-pipe and obstacle units, and replaces their free-running divided clocks with one sys_clk and enables.

Parameters:
- V_ACTIVE, 480: first non-visible row; a frame update is triggered when counter_y enters this row.
- FRAME_DIV, 1: run one update every FRAME_DIV frames (1..15).
- TIMEOUT, 1023: max cycles to wait for any unit's done before declaring a fault.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- counter_y, in, 10: current row from the sync generator.
- start, in, 1: single-cycle debounced start pulse.
- ack, in, 1: single-cycle debounced acknowledge pulse.
- jump, in, 1: single-cycle debounced jump pulse.
- phys_go, out, 1: one-cycle start strobe to flight physics.
- phys_jump, out, 1: level jump request, valid while the physics step is in progress.
- phys_done, in, 1: physics step complete.
- scroll_go, out, 1: one-cycle start strobe to pipe scroll.
- scroll_done, in, 1: scroll step complete.
- scroll_pass, in, 1: pipe passed the bird; sampled only with scroll_done.
- coll_go, out, 1: one-cycle start strobe to collision check.
- coll_done, in, 1: collision check complete.
- coll_hit, in, 1: collision detected; sampled only with coll_done.
- commit, out, 1: one-cycle strobe telling units to publish new positions to the renderer.
- q_initial, out, 1: one-hot game state bit (Initial).
- q_play, out, 1: one-hot game state bit (Play).
- q_lose, out, 1: one-hot game state bit (Lose).
- score, out, 8: player score.
- fault, out, 1: sticky handshake-timeout flag.
- miss_cnt, out, 8: count of vblank edges that arrived while the sequencer was busy.

Behaviour:
- Reset (synchronous, any state): q_initial=1; q_play=0; q_lose=0; all go strobes, commit and phys_jump=0; score=0; fault=0; miss_cnt=0; jump latch clear; frame divider=0; sequencer in S_WAIT; prev_y register=0.
- Game FSM:
  - INITIAL -> PLAY on start. On this transition score clears and the divider clears.
  - PLAY -> LOSE when a collision check finishes with coll_done=1 and coll_hit=1, or on any timeout.
  - LOSE -> INITIAL on ack.
  - start is ignored outside INITIAL; ack is ignored outside LOSE.
- Vblank edge: vb_edge = (counter_y == V_ACTIVE) && (prev_y != V_ACTIVE). prev_y is updated every cycle.
- Frame divider: counts vb_edge events while in PLAY. fire = vb_edge && divider == FRAME_DIV-1; on fire the divider wraps to 0.
- Sequencer states, active only in PLAY:
  - S_WAIT: on fire, go to S_PHYS.
  - S_PHYS: phys_go=1 in the first cycle only; wait for phys_done.
  - S_SCROLL: scroll_go=1 in the first cycle only; wait for scroll_done.
  - S_COLL: coll_go=1 in the first cycle only; wait for coll_done.
  - S_COMMIT: one cycle, commit=1, then back to S_WAIT.
- Go latency: if fire occurs in cycle t, phys_go is asserted in cycle t+1. Each subsequent go is asserted in the cycle after the previous unit's done was sampled.
- Done sampling: done is ignored in the cycle its go is asserted and accepted from the next cycle on. A done seen in any other state is ignored.
- Jump latch:
  - Set by jump in PLAY, in any sequencer state.
  - phys_jump = latch, held for the whole S_PHYS step.
  - The latch clears on the cycle phys_done is accepted, unless a new jump arrives in that same cycle, in which case it stays set for the next frame.
- Score: scroll_pass captured with scroll_done sets a pending flag. On commit, score increments by 1 and saturates at 255. If the check ended in a hit, no commit occurs and the pending pass is dropped.
- Hit path: on coll_done && coll_hit the sequencer goes to S_WAIT with no commit, and the game state goes to LOSE in the same cycle.
- Timeout:
  - A per-step counter clears on entry to S_PHYS, S_SCROLL and S_COLL.
  - If it reaches TIMEOUT without done: fault=1 (sticky until reset), game goes to LOSE, sequencer goes to S_WAIT.
- Overrun: a fire while the sequencer is not in S_WAIT increments miss_cnt (saturates at 255). The frame is skipped, not queued.
- Leaving PLAY: all strobes are forced to 0 and the sequencer returns to S_WAIT within one cycle; in-flight dones are discarded.
- Outputs: all outputs are registered; exactly one of q_initial, q_play, q_lose is high at all times.

Decomposition:
- Shared package flappy_pkg: game-state encoding, sequencer state enum, V_ACTIVE/V_TOTAL constants, score width.
- One natural sub-module, step_watchdog: loadable timeout counter with expired output, instantiated once and shared across steps.

Test Plan:
- Reset, start, then counter_y 479->480 -> phys_go at the edge cycle +1. With phys_done, scroll_done and coll_done each returned 3 cycles after their go: commit=1 at edge+13, score stays 0.
- scroll_pass=1 with scroll_done, coll_hit=0 -> score 0->1 on commit. Preload 255 and repeat -> score stays 255.
- coll_done with coll_hit=1 -> q_lose=1 the next cycle, no commit. Then ack -> q_initial=1. A start pulse sent while in LOSE is ignored.
- phys_done withheld for 1023 cycles -> fault=1, q_lose=1. ack -> q_initial=1 with fault still 1. reset -> fault=0.
- FRAME_DIV=2 -> phys_go on every second vblank edge. Hold coll_done low across a further edge -> miss_cnt=1, and no second phys_go for that frame.
- jump pulse during S_COLL -> phys_jump=1 throughout the next S_PHYS and clears after phys_done. jump in the same cycle as phys_done -> phys_jump=1 again in the following frame.
